// File: rtl/keypad_scan.sv
// -----------------------------------------------------------------------------
// keypad_scan
//
// Scans a 4-row x 3-column telephone keypad (1 2 3 / 4 5 6 / 7 8 9 / * 0 #),
// builds one key map per full scan frame, and debounces the per-frame key code
// before presenting it to the time-setting logic downstream.
//
// Ports
//   clk         in   system clock (1 kHz)
//   rst         in   asynchronous, active-high reset
//   key_row     in   [3:0] keypad rows, active-low, row0 = top, async to clk
//   key_col     out  [2:0] column drive, active-low one-cold, col0 = left
//   num_input   out  [9:0] one-hot level, bit n = digit n held (debounced)
//   set_time    out  one-cycle pulse on an accepted '#' press
//   star_pulse  out  one-cycle pulse on an accepted '*' press
//   key_code    out  [3:0] stable code: 0-9 digit, 10 '*', 11 '#', 15 none
//   key_valid   out  one-cycle strobe on each accepted key press
// -----------------------------------------------------------------------------
module keypad_scan #(
  parameter int SCAN_TICKS      = 4,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_row,
  output logic [2:0] key_col,
  output logic [9:0] num_input,
  output logic       set_time,
  output logic       star_pulse,
  output logic [3:0] key_code,
  output logic       key_valid
);

  localparam int TICK_W = $clog2(SCAN_TICKS);
  localparam int CNT_W  = $clog2(DEBOUNCE_FRAMES + 1);

  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(SCAN_TICKS - 1);
  localparam logic [CNT_W-1:0]  CNT_ACCEPT = CNT_W'(DEBOUNCE_FRAMES);

  localparam logic [3:0] CODE_NONE = 4'hF;
  localparam logic [3:0] CODE_STAR = 4'd10;
  localparam logic [3:0] CODE_HASH = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONFIRM,
    S_HELD
  } state_t;

  // Map bit index (row*3+col) to key code; anything but a single key is "none",
  // which also rejects ghosting from multi-key presses.
  function automatic logic [3:0] frame_code(input logic [11:0] map);
    logic [3:0] n_set;
    logic [3:0] idx;
    logic [3:0] code;
    n_set = 4'd0;
    idx   = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (map[i]) begin
        n_set = n_set + 4'd1;
        idx   = 4'(i);
      end
    end
    if (n_set != 4'd1) begin
      code = CODE_NONE;
    end else begin
      case (idx)
        4'd9:    code = CODE_STAR;
        4'd10:   code = 4'd0;
        4'd11:   code = CODE_HASH;
        default: code = idx + 4'd1;
      endcase
    end
    return code;
  endfunction

  function automatic logic [9:0] digit_onehot(input logic [3:0] code);
    return (code < 4'd10) ? (10'd1 << code) : 10'd0;
  endfunction

  logic [3:0]        r_row_p0;
  logic [3:0]        r_row_p1;
  logic [TICK_W-1:0] r_tick;
  logic [1:0]        r_col;
  logic [11:0]       r_map;
  state_t            r_state;
  logic [3:0]        r_cand;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_slot_end;
  logic              w_frame_end;
  logic [3:0]        w_row_act;
  logic [11:0]       w_map_cur;
  logic [3:0]        w_code;
  logic [CNT_W-1:0]  w_cnt_new;
  logic              w_cand_done;

  // ---- stage p0/p1: two-flop synchronizer on the raw rows ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_p0 <= 4'hF;
      r_row_p1 <= 4'hF;
    end else begin
      r_row_p0 <= key_row;
      r_row_p1 <= r_row_p0;
    end
  end

  // ---- scan: column rotation and frame map accumulation ----
  assign w_slot_end  = (r_tick == TICK_LAST);
  assign w_frame_end = w_slot_end && (r_col == 2'd2);
  assign w_row_act   = ~r_row_p1;

  always_comb begin
    w_map_cur = r_map;
    case (r_col)
      2'd0: begin
        w_map_cur[0] = r_map[0] | w_row_act[0];
        w_map_cur[3] = r_map[3] | w_row_act[1];
        w_map_cur[6] = r_map[6] | w_row_act[2];
        w_map_cur[9] = r_map[9] | w_row_act[3];
      end
      2'd1: begin
        w_map_cur[1]  = r_map[1]  | w_row_act[0];
        w_map_cur[4]  = r_map[4]  | w_row_act[1];
        w_map_cur[7]  = r_map[7]  | w_row_act[2];
        w_map_cur[10] = r_map[10] | w_row_act[3];
      end
      2'd2: begin
        w_map_cur[2]  = r_map[2]  | w_row_act[0];
        w_map_cur[5]  = r_map[5]  | w_row_act[1];
        w_map_cur[8]  = r_map[8]  | w_row_act[2];
        w_map_cur[11] = r_map[11] | w_row_act[3];
      end
      default: w_map_cur = r_map;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick  <= '0;
      r_col   <= 2'd0;
      key_col <= 3'b110;
      r_map   <= '0;
    end else if (w_slot_end) begin
      r_tick  <= '0;
      r_col   <= (r_col == 2'd2) ? 2'd0 : r_col + 2'd1;
      key_col <= {key_col[1:0], key_col[2]};
      r_map   <= w_frame_end ? 12'd0 : w_map_cur;
    end else begin
      r_tick  <= r_tick + TICK_W'(1);
    end
  end

  // ---- debounce: frame code vs. candidate, evaluated at frame end ----
  assign w_code = frame_code(w_map_cur);

  // The candidate counter only continues when the same code repeats; any
  // other differing code restarts it at 1. r_cnt never exceeds the accept
  // threshold, so the increment cannot wrap.
  assign w_cnt_new   = ((w_code == r_cand) && (r_cnt != '0)) ? r_cnt + CNT_W'(1)
                                                             : CNT_W'(1);
  assign w_cand_done = (w_cnt_new == CNT_ACCEPT);

  // key_code doubles as the stable state: a frame matching it keeps the FSM
  // where it is, anything else must persist to be accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cand     <= CODE_NONE;
      r_cnt      <= '0;
      key_code   <= CODE_NONE;
      num_input  <= '0;
      key_valid  <= 1'b0;
      set_time   <= 1'b0;
      star_pulse <= 1'b0;
    end else begin
      key_valid  <= 1'b0;
      set_time   <= 1'b0;
      star_pulse <= 1'b0;
      if (w_frame_end) begin
        if (w_code == key_code) begin
          r_cnt   <= '0;
          r_cand  <= CODE_NONE;
          r_state <= (key_code == CODE_NONE) ? S_IDLE : S_HELD;
        end else if (w_cand_done) begin
          r_cnt     <= '0;
          r_cand    <= CODE_NONE;
          key_code  <= w_code;
          num_input <= digit_onehot(w_code);
          if (w_code == CODE_NONE) begin
            r_state <= S_IDLE;
          end else begin
            r_state    <= S_HELD;
            key_valid  <= 1'b1;
            set_time   <= (w_code == CODE_HASH);
            star_pulse <= (w_code == CODE_STAR);
          end
        end else begin
          r_cand  <= w_code;
          r_cnt   <= w_cnt_new;
          r_state <= (r_state == S_HELD) ? S_HELD : S_CONFIRM;
        end
      end
    end
  end

endmodule
